// File: rtl/memory_island_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_island_arb_pkg: shared types and round-robin pick helper      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_island_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    // First asserted request at or above ptr, wrapping at num; returns ptr if none.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int num);
        int idx;
        rr_pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num) begin
                idx = ptr + i;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (req[idx[MAX_REQ_W-1:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_island_arb_idx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_island_arb_idx_fifo: requester-index FIFO, no fall-through    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_island_arb_idx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CNT_W = $clog2(Depth + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Depth - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(Depth);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [PTR_W-1:0]            wr_q, rd_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == LAST_PTR) ? '0 : wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_island_wide_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_island_wide_arbiter: round-robin OBI arbiter onto one wide    |
// | memory port with in-order response steering.                         |
// | Optional MEMORY_ISLAND_ARB_PERF_EN adds stall/full counters.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_island_wide_arbiter
    import memory_island_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 3,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 256,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned StrbWidth      = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_i,
    output logic [NumReq-1:0]                   gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]    strb_i,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [NumReq-1:0][DataWidth-1:0]    rdata_o,
    output logic                                wide_req_o,
    input  logic                                wide_gnt_i,
    output logic [AddrWidth-1:0]                wide_addr_o,
    output logic                                wide_we_o,
    output logic [DataWidth-1:0]                wide_wdata_o,
    output logic [StrbWidth-1:0]                wide_strb_o,
    input  logic                                wide_rvalid_i,
    input  logic [DataWidth-1:0]                wide_rdata_i
`ifdef MEMORY_ISLAND_ARB_PERF_EN
    ,
    output logic [NumReq-1:0][31:0]             perf_stall_o,
    output logic [31:0]                         perf_full_o
`endif
);

    localparam int unsigned IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MaxOutstanding);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NumReq - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   pick, sel, head;
    logic [MAX_REQ-1:0] req_pad;
    logic               full, push, pop, fifo_full, fifo_empty;

    assign req_pad = MAX_REQ'(req_i);
    assign pick    = IDX_W'(rr_pick(req_pad, int'(rr_q), int'(NumReq)));
    assign sel     = (state_q == ARB_LOCK) ? sel_q : pick;

    // Full masks the request even if a pop lands this cycle: no rvalid->req path.
    assign full       = (cnt_q == MAX_CNT);
    assign wide_req_o = req_i[sel] & ~full;
    assign push       = wide_req_o & wide_gnt_i;
    assign pop        = wide_rvalid_i & ~fifo_empty;

    assign wide_addr_o  = addr_i[sel];
    assign wide_we_o    = we_i[sel];
    assign wide_wdata_o = wdata_i[sel];
    assign wide_strb_o  = strb_i[sel];
    assign rdata_o      = {NumReq{wide_rdata_i}};

    always_comb begin
        gnt_o          = '0;
        rvalid_o       = '0;
        gnt_o[sel]     = push;
        rvalid_o[head] = pop;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (wide_req_o && !wide_gnt_i) begin
                    state_d = ARB_LOCK;
                    sel_d   = pick;
                end
            end
            ARB_LOCK: begin
                if (push || !req_i[sel_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (push) begin
            rr_d = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    memory_island_arb_idx_fifo #(
        .Depth (MaxOutstanding),
        .Width (IDX_W)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef MEMORY_ISLAND_ARB_PERF_EN
    logic [NumReq-1:0][31:0] perf_stall_q;
    logic [31:0]             perf_full_q;

    for (genvar k = 0; k < NumReq; k++) begin : g_perf_stall
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                perf_stall_q[k] <= '0;
            end else if (req_i[k] && !gnt_o[k] && (perf_stall_q[k] != '1)) begin
                perf_stall_q[k] <= perf_stall_q[k] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_full_q <= '0;
        end else if (full && (perf_full_q != '1)) begin
            perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_full_o  = perf_full_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_no_stray_rvalid : assert (!(wide_rvalid_i && fifo_empty))
                else $warning("wide_rvalid_i with no outstanding request ignored");
            a_lock_held : assert (!(state_q == ARB_LOCK && !req_i[sel_q]))
                else $warning("locked requester dropped req_i before grant");
            a_count_track : assert (fifo_full == full);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_island_wide_arbiter.sv
`default_nettype none
// Testbench for memory_island_wide_arbiter: directed scenarios plus a randomized
// run, all checked against a queue-based behavioural model.
module tb_memory_island_wide_arbiter;

    localparam int N    = 3;
    localparam int MAXO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req, gnt, we, rvalid;
    logic [N-1:0][31:0] addr, strb;
    logic [N-1:0][255:0] wdata, rdata;
    logic               wreq, wgnt, wwe, wrvalid;
    logic [31:0]        waddr, wstrb;
    logic [255:0]       wwdata, wrdata;
`ifdef MEMORY_ISLAND_ARB_PERF_EN
    logic [N-1:0][31:0] perf_stall;
    logic [31:0]        perf_full;
`endif

    int total = 0;
    int bad   = 0;

    memory_island_wide_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .gnt_o         (gnt),
        .addr_i        (addr),
        .we_i          (we),
        .wdata_i       (wdata),
        .strb_i        (strb),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .wide_req_o    (wreq),
        .wide_gnt_i    (wgnt),
        .wide_addr_o   (waddr),
        .wide_we_o     (wwe),
        .wide_wdata_o  (wwdata),
        .wide_strb_o   (wstrb),
        .wide_rvalid_i (wrvalid),
        .wide_rdata_i  (wrdata)
`ifdef MEMORY_ISLAND_ARB_PERF_EN
        ,
        .perf_stall_o  (perf_stall),
        .perf_full_o   (perf_full)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pointer, optional locked requester, queue of outstanding indices.
    int     m_rr;
    bit     m_locked;
    int     m_lock;
    int     m_q[$];
    bit     e_wreq, e_push, e_pop;
    int     e_sel;
    logic [N-1:0] e_gnt, e_rvalid;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void predict();
        bit found = 0;
        e_sel = m_rr;
        if (m_locked) e_sel = m_lock;
        else begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[(m_rr + i) % N]) begin
                    e_sel = (m_rr + i) % N;
                    found = 1;
                end
            end
        end
        e_wreq   = (m_q.size() < MAXO) && req[e_sel];
        e_push   = e_wreq && wgnt;
        e_gnt    = e_push ? (3'b001 << e_sel) : 3'b000;
        e_pop    = wrvalid && (m_q.size() > 0);
        e_rvalid = e_pop ? (3'b001 << m_q[0]) : 3'b000;
    endfunction

    function automatic void commit();
        if (e_pop) void'(m_q.pop_front());
        if (e_push) begin
            m_q.push_back(e_sel);
            m_rr     = (e_sel + 1) % N;
            m_locked = 0;
        end else if (m_locked && !req[m_lock]) begin
            m_locked = 0;
        end else if (e_wreq) begin
            m_locked = 1;
            m_lock   = e_sel;
        end
    endfunction

    task automatic tick();
        predict();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; wgnt = 0; wrvalid = 0; wrdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        @(posedge clk);
        m_rr = 0; m_locked = 0; m_lock = 0; m_q.delete();
        #1;
        rst = 0;
    endtask

    task automatic drain(input int n);
        idle_inputs();
        wrvalid = 1;
        repeat (n) tick();
        wrvalid = 0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            addr[k] = $urandom; we[k] = 0; wdata[k] = rand256(); strb[k] = $urandom;
        end
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        m_rr = 0; m_locked = 0; m_lock = 0; m_q.delete();
        #1;
        rst = 0;
        @(negedge clk);
        total++; if (wreq !== 1'b0) begin bad++; $display("FAIL reset_wreq: got %b want 0", wreq); end
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL reset_rvalid: got %b want 000", rvalid); end
        tick();
        req = 3'b111; wgnt = 1;
        @(negedge clk); predict();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL reset_first_pick: got %b want 001", gnt); end
        total++; if (waddr !== addr[0]) begin bad++; $display("FAIL reset_first_addr: got %h want %h", waddr, addr[0]); end
        tick();
        drain(1);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_oh;
        req = 3'b111; wgnt = 1;
        for (int c = 0; c < 6; c++) begin
            wrvalid = (c > 0);
            wrdata  = rand256();
            exp_oh  = 3'b001 << ((c + 1) % 3);
            @(negedge clk); predict();
            total++; if (gnt !== exp_oh) begin bad++; $display("FAIL rr_order c%0d: got %b want %b", c, gnt, exp_oh); end
            total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, rvalid, e_rvalid); end
            tick();
        end
        // Pointer has come back around to requester 1's successor order.
        wrvalid = 1;
        @(negedge clk); predict();
        total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rr_wrap: got %b want %b", gnt, e_gnt); end
        tick();
        drain(1);
    endtask

    task automatic test_lock();
        idle_inputs();
        req = 3'b100;
        addr[2] = $urandom; addr[0] = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); predict();
            total++; if (wreq !== 1'b1 || waddr !== addr[2]) begin bad++; $display("FAIL lock_hold c%0d: got req=%b addr=%h want 1 %h", c, wreq, waddr, addr[2]); end
            total++; if (gnt !== 3'b000) begin bad++; $display("FAIL lock_nognt c%0d: got %b want 000", c, gnt); end
            tick();
        end
        req = 3'b101;
        @(negedge clk); predict();
        total++; if (waddr !== addr[2]) begin bad++; $display("FAIL lock_ignore_new: got %h want %h", waddr, addr[2]); end
        tick();
        wgnt = 1;
        @(negedge clk); predict();
        total++; if (gnt !== 3'b100) begin bad++; $display("FAIL lock_grant: got %b want 100", gnt); end
        tick();
        req = 3'b001;
        @(negedge clk); predict();
        total++; if (gnt !== 3'b001 || waddr !== addr[0]) begin bad++; $display("FAIL lock_next_pick: got %b %h want 001 %h", gnt, waddr, addr[0]); end
        tick();
        drain(2);
    endtask

    task automatic test_ordering();
        logic [255:0] d[3];
        logic [N-1:0] exp_rv[3];
        for (int i = 0; i < 3; i++) d[i] = rand256();
        exp_rv[0] = 3'b010; exp_rv[1] = 3'b001; exp_rv[2] = 3'b010;
        idle_inputs();
        wgnt = 1;
        for (int k = 0; k < N; k++) we[k] = 0;
        for (int c = 0; c < 5; c++) begin
            req     = (c < 3) ? exp_rv[c] : 3'b000;
            wrvalid = (c >= 2);
            wrdata  = (c >= 2) ? d[c-2] : '0;
            @(negedge clk); predict();
            total++; if (gnt !== e_gnt) begin bad++; $display("FAIL order_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
            if (c >= 2) begin
                total++; if (rvalid !== exp_rv[c-2]) begin bad++; $display("FAIL order_rvalid c%0d: got %b want %b", c, rvalid, exp_rv[c-2]); end
                total++; if (rdata[c == 3 ? 0 : 1] !== d[c-2]) begin bad++; $display("FAIL order_rdata c%0d: got %h want %h", c, rdata[c == 3 ? 0 : 1], d[c-2]); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        idle_inputs();
        wgnt = 1;
        for (int c = 0; c < MAXO; c++) begin
            req = 3'b001 << $urandom_range(0, N - 1);
            @(negedge clk); predict();
            total++; if (gnt !== req) begin bad++; $display("FAIL full_fill c%0d: got %b want %b", c, gnt, req); end
            tick();
        end
        req = 3'b010;
        @(negedge clk); predict();
        total++; if (wreq !== 1'b0 || gnt !== 3'b000) begin bad++; $display("FAIL full_block: got req=%b gnt=%b want 0 000", wreq, gnt); end
        tick();
        wrvalid = 1; wrdata = rand256();
        @(negedge clk); predict();
        total++; if (wreq !== 1'b0) begin bad++; $display("FAIL full_pop_same_cycle: got %b want 0", wreq); end
        total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL full_pop_rvalid: got %b want %b", rvalid, e_rvalid); end
        tick();
        wrvalid = 0;
        @(negedge clk); predict();
        total++; if (wreq !== 1'b1 || gnt !== 3'b010) begin bad++; $display("FAIL full_release: got req=%b gnt=%b want 1 010", wreq, gnt); end
        tick();
        drain(MAXO);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wgnt    = ($urandom_range(0, 3) != 0);
            wrvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            wrdata  = rand256();
            @(negedge clk); predict();
            total++; if (wreq !== e_wreq || gnt !== e_gnt) begin bad++; $display("FAIL rand_arb c%0d: got req=%b gnt=%b want %b %b", c, wreq, gnt, e_wreq, e_gnt); end
            total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL rand_rvalid c%0d: got %b want %b", c, rvalid, e_rvalid); end
            if (e_wreq) begin
                total++;
                if (waddr !== addr[e_sel] || wwe !== we[e_sel] || wwdata !== wdata[e_sel] || wstrb !== strb[e_sel]) begin
                    bad++; $display("FAIL rand_payload c%0d: got addr=%h we=%b want addr=%h we=%b", c, waddr, wwe, addr[e_sel], we[e_sel]);
                end
            end
            tick();
            for (int k = 0; k < N; k++) begin
                if (e_gnt[k]) req[k] = 0;
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1; addr[k] = $urandom; we[k] = $urandom_range(0, 1);
                    wdata[k] = rand256(); strb[k] = $urandom;
                end
            end
        end
        idle_inputs();
        drain(MAXO);
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        wgnt = 1;
        req = 3'b001; tick();
        req = 3'b010; tick();
        do_reset();
        wrvalid = 1; wrdata = rand256();
        @(negedge clk); predict();
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL midop_stray_rvalid: got %b want 000", rvalid); end
        tick();
        idle_inputs();
        wgnt = 1;
        for (int c = 0; c <= MAXO; c++) begin
            req = 3'b100;
            @(negedge clk); predict();
            total++; if (wreq !== (c < MAXO)) begin bad++; $display("FAIL midop_refill c%0d: got %b want %b", c, wreq, (c < MAXO)); end
            tick();
        end
        drain(MAXO);
    endtask

`ifdef MEMORY_ISLAND_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        req = 3'b010; wgnt = 0;
        repeat (7) tick();
        @(negedge clk);
        total++; if (perf_stall[1] !== 32'd7) begin bad++; $display("FAIL perf_stall1: got %0d want 7", perf_stall[1]); end
        total++; if (perf_stall[0] !== 32'd0 || perf_full !== 32'd0) begin bad++; $display("FAIL perf_others: got %0d %0d want 0 0", perf_stall[0], perf_full); end
        wgnt = 1; tick();
        drain(1);
    endtask
`endif

    initial begin
        rst = 1;
        idle_inputs();
        addr = '0; we = '0; wdata = '0; strb = '0;
        m_rr = 0; m_locked = 0; m_lock = 0;
        test_reset();
        test_round_robin();
        test_lock();
        test_ordering();
        test_full();
        test_random();
        test_reset_midop();
`ifdef MEMORY_ISLAND_ARB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
